mem_arbiter: RTL and testbench
==============================

# mem_arbiter

- Two-requester arbiter for the single-port program/data memory.
- Shares the memory between the CPU (instruction fetch plus LW/SW) and a debug/loader port.
- Requests use a level-sensitive req/ack handshake; the arbiter holds each access for a fixed number of wait cycles and returns read data in a register.
- Sits between the CPU core and the memory model and drives the memory's active-low write strobe.

## Interface
Parameters:
- AW, 16, address width
- DW, 16, data width
- LAT, 1, wait cycles per access; legal range 1..15

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- c_req  in  1  CPU request, level, held until c_ack
- c_we  in  1  CPU write (1) / read (0)
- c_addr  in  AW  CPU address
- c_wdata  in  DW  CPU write data
- c_ack  out  1  CPU access complete, 1-cycle pulse
- c_rdata  out  DW  CPU read data, registered
- d_req, d_we, d_addr, d_wdata, d_ack, d_rdata: debug port, same widths and semantics as the CPU port
- mem_addr  out  AW  memory address, registered
- mem_wdata  out  DW  memory write data, registered
- mem_nwe  out  1  memory write strobe, active-low
- mem_rdata  in  DW  memory read data, combinational from mem_addr
- busy  out  1  high whenever state != IDLE
- gnt_d  out  1  current/last grant owner: 0 = CPU, 1 = debug

## Operation
FSM states: IDLE, ACCESS, DONE.

**IDLE**
- If neither req is high: stay in IDLE.
- If exactly one req is high: grant that requester.
- If both are high: grant the requester not in last_grant (round-robin).
- On a grant:
  - latch the granted addr into mem_addr and the granted wdata into mem_wdata;
  - set mem_nwe = ~we;
  - load cnt = LAT;
  - set last_grant and gnt_d to the granted requester;
  - go to ACCESS.

**ACCESS**
- mem_addr, mem_wdata and mem_nwe are held stable.
- cnt decrements by 1 on each edge.
- On the edge where cnt == 1:
  - for a read, capture mem_rdata into the granted port's rdata; for a write, leave rdata unchanged;
  - set the granted port's ack = 1;
  - set mem_nwe = 1;
  - go to DONE.

**DONE**
- Clear ack.
- Go to IDLE.
- Requesters must deassert req (or present a new request) by the cycle following ack. Because arbitration only happens in IDLE, a stale req is never re-sampled during DONE.

Other rules:
- Requester inputs are sampled only in IDLE. Changes to addr, we or wdata after the grant have no effect.
- A req dropped during ACCESS does not abort the access; the access completes and the ack still pulses.
- No access ever reaches the memory with mem_nwe low outside ACCESS.
- LAT = 0 is illegal. Flag it with a simulation-time assertion; behaviour is then undefined.
- cnt is 4 bits.

## Timing
Reset (asynchronous, takes effect immediately, including mid-access):
- state = IDLE
- mem_nwe = 1 (aborts any write in progress)
- mem_addr = 0, mem_wdata = 0
- c_ack = d_ack = 0
- c_rdata = d_rdata = 0
- last_grant = debug, so the CPU wins the first tie
- gnt_d = 1, busy = 0

Latency, with req sampled high in IDLE at edge E0:
- busy = 1 from E0.
- mem_nwe is low from E0 to E(LAT) for writes.
- ack is high from E(LAT) to E(LAT+1).
- rdata is valid from E(LAT) and holds until the next read by the same port.
- The next grant is possible at E(LAT+2).
- Throughput: one access per LAT+2 cycles.

Simultaneous events:
- Both requests high continuously: grants alternate strictly, CPU first after reset.
- One requester's req rises during another's access: it is served at the next IDLE.

## Test plan
1. **Reset:** assert rst mid-cycle. All outputs take their reset values without waiting for a clock edge: mem_nwe = 1, busy = 0, gnt_d = 1, both rdata = 0.
2. **CPU read, LAT = 2:** c_req with c_addr = 0x0010, memory returns 0xBEEF at 0x0010.
   - mem_addr = 0x0010 from E0.
   - c_ack high exactly E2..E3, c_rdata = 0xBEEF.
   - d_ack stays 0; busy low again after E3.
3. **Debug write, LAT = 1:** d_req, d_we = 1, d_addr = 0x0040, d_wdata = 0x1234.
   - mem_nwe low exactly E0..E1, mem_wdata = 0x1234, d_ack pulses E1..E2.
   - A follow-up CPU read of 0x0040 returns 0x1234.
4. **Contention:** after reset, c_req and d_req held high for four accesses.
   - Grant order is CPU, debug, CPU, debug; gnt_d toggles accordingly.
   - Acks are spaced LAT+2 cycles apart.
5. **Abort on reset:** debug write in progress (LAT = 4); rst pulsed two cycles after the grant.
   - mem_nwe returns to 1 immediately, no ack is issued, memory at the target address keeps its old value.
   - After reset, the next CPU request is served normally.
6. **Early req drop:** c_req deasserted one cycle after the grant.
   - The access still completes and c_ack pulses once.
   - No second access starts in IDLE.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin req/ack arbiter sharing one single-port memory between CPU and debug ports
// Ports: clk/rst (async, active-high); c_* CPU port and d_* debug port (req, we, addr, wdata in;
// ack pulse, registered rdata out); mem_addr/mem_wdata/mem_nwe drive the memory, mem_rdata is its
// combinational read data; busy is high outside IDLE; gnt_d is the current/last grant owner (1 = debug).
module mem_arbiter #(
  parameter int AW = 16,
  parameter int DW = 16,
  parameter int LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_ack,
  output logic [DW-1:0] c_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_nwe,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          gnt_d
);
  localparam logic [1:0] IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2;
  logic [1:0] state;
  logic [3:0] cnt;
  logic       pick_d;
  // gnt_d doubles as the round-robin memory: on a tie the port that did not win last time is served
  assign pick_d = d_req & (~c_req | ~gnt_d);
  assign busy = state != IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      gnt_d     <= 1'b1;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_nwe   <= 1'b1;
      c_ack     <= 1'b0;
      d_ack     <= 1'b0;
      c_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      case (state)
        IDLE: if (c_req | d_req) begin
          gnt_d     <= pick_d;
          mem_addr  <= pick_d ? d_addr : c_addr;
          mem_wdata <= pick_d ? d_wdata : c_wdata;
          mem_nwe   <= pick_d ? ~d_we : ~c_we;
          cnt       <= 4'(LAT);
          state     <= ACCESS;
        end
        ACCESS: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            // mem_nwe still high here means the access is a read
            if (gnt_d) begin
              d_ack <= 1'b1;
              if (mem_nwe) d_rdata <= mem_rdata;
            end else begin
              c_ack <= 1'b1;
              if (mem_nwe) c_rdata <= mem_rdata;
            end
            mem_nwe <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          c_ack <= 1'b0;
          d_ack <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  lat_legal: assert property (@(posedge clk) LAT >= 1 && LAT <= 15);
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed tests of mem_arbiter at LAT = 1, 2 and 4 against a small memory model
module tb_mem_arbiter;
  logic        clk, rst;
  logic        c_req[3], c_we[3], c_ack[3], d_req[3], d_we[3], d_ack[3];
  logic        mem_nwe[3], busy[3], gnt_d[3];
  logic [15:0] c_addr[3], c_wdata[3], c_rdata[3], d_addr[3], d_wdata[3], d_rdata[3];
  logic [15:0] mem_addr[3], mem_wdata[3], mem_rdata[3];
  bit   [15:0] mem[3][256];
  bit          wr[3][256];
  bit          pend[3];
  logic [7:0]  pa[3];
  logic [15:0] pd[3];
  int pass_cnt = 0, total = 0;

  function automatic logic [15:0] pat(input logic [15:0] a);
    return a == 16'h0010 ? 16'hBEEF : {8'hA5, a[7:0]};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_arbiter #(.AW(16), .DW(16), .LAT(g == 0 ? 1 : g == 1 ? 2 : 4)) u_dut (
      .clk(clk), .rst(rst),
      .c_req(c_req[g]), .c_we(c_we[g]), .c_addr(c_addr[g]), .c_wdata(c_wdata[g]),
      .c_ack(c_ack[g]), .c_rdata(c_rdata[g]),
      .d_req(d_req[g]), .d_we(d_we[g]), .d_addr(d_addr[g]), .d_wdata(d_wdata[g]),
      .d_ack(d_ack[g]), .d_rdata(d_rdata[g]),
      .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]), .mem_nwe(mem_nwe[g]),
      .mem_rdata(mem_rdata[g]), .busy(busy[g]), .gnt_d(gnt_d[g])
    );
    assign mem_rdata[g] = wr[g][mem_addr[g][7:0]] ? mem[g][mem_addr[g][7:0]] : pat(mem_addr[g]);
  end

  // A write commits only once the strobe ends normally; a reset during the strobe discards it
  always @(negedge clk or posedge rst)
    for (int k = 0; k < 3; k++)
      if (rst) pend[k] <= 1'b0;
      else if (!mem_nwe[k]) begin
        pend[k] <= 1'b1;
        pa[k]   <= mem_addr[k][7:0];
        pd[k]   <= mem_wdata[k];
      end else if (pend[k]) begin
        mem[k][pa[k]] <= pd[k];
        wr[k][pa[k]]  <= 1'b1;
        pend[k]       <= 1'b0;
      end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    @(negedge clk);
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      total++; if (mem_nwe[k] !== 1'b1) $display("FAIL reset_nwe[%0d]: got %b want 1", k, mem_nwe[k]); else pass_cnt++;
      total++; if (busy[k] !== 1'b0) $display("FAIL reset_busy[%0d]: got %b want 0", k, busy[k]); else pass_cnt++;
      total++; if (gnt_d[k] !== 1'b1) $display("FAIL reset_gnt_d[%0d]: got %b want 1", k, gnt_d[k]); else pass_cnt++;
      total++; if (c_rdata[k] !== 16'h0) $display("FAIL reset_c_rdata[%0d]: got %h want 0000", k, c_rdata[k]); else pass_cnt++;
      total++; if (d_rdata[k] !== 16'h0) $display("FAIL reset_d_rdata[%0d]: got %h want 0000", k, d_rdata[k]); else pass_cnt++;
      total++; if ({c_ack[k], d_ack[k]} !== 2'b00) $display("FAIL reset_acks[%0d]: got %b%b want 00", k, c_ack[k], d_ack[k]); else pass_cnt++;
      total++; if (mem_addr[k] !== 16'h0) $display("FAIL reset_mem_addr[%0d]: got %h want 0000", k, mem_addr[k]); else pass_cnt++;
      total++; if (mem_wdata[k] !== 16'h0) $display("FAIL reset_mem_wdata[%0d]: got %h want 0000", k, mem_wdata[k]); else pass_cnt++;
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_cpu_read;
    c_addr[1] = 16'h0010; c_we[1] = 1'b0; c_req[1] = 1'b1;
    tick();
    total++; if (mem_addr[1] !== 16'h0010) $display("FAIL rd_mem_addr: got %h want 0010", mem_addr[1]); else pass_cnt++;
    total++; if (busy[1] !== 1'b1) $display("FAIL rd_busy_e0: got %b want 1", busy[1]); else pass_cnt++;
    total++; if (gnt_d[1] !== 1'b0) $display("FAIL rd_gnt_d: got %b want 0", gnt_d[1]); else pass_cnt++;
    total++; if (mem_nwe[1] !== 1'b1) $display("FAIL rd_nwe: got %b want 1", mem_nwe[1]); else pass_cnt++;
    tick();
    total++; if (c_ack[1] !== 1'b0) $display("FAIL rd_ack_e1: got %b want 0", c_ack[1]); else pass_cnt++;
    tick();
    total++; if (c_ack[1] !== 1'b1) $display("FAIL rd_ack_e2: got %b want 1", c_ack[1]); else pass_cnt++;
    total++; if (c_rdata[1] !== 16'hBEEF) $display("FAIL rd_rdata: got %h want BEEF", c_rdata[1]); else pass_cnt++;
    total++; if (d_ack[1] !== 1'b0) $display("FAIL rd_d_ack: got %b want 0", d_ack[1]); else pass_cnt++;
    c_req[1] = 1'b0;
    tick();
    total++; if (c_ack[1] !== 1'b0) $display("FAIL rd_ack_e3: got %b want 0", c_ack[1]); else pass_cnt++;
    total++; if (busy[1] !== 1'b0) $display("FAIL rd_busy_e3: got %b want 0", busy[1]); else pass_cnt++;
  endtask

  task automatic test_debug_write;
    d_we[0] = 1'b1; d_addr[0] = 16'h0040; d_wdata[0] = 16'h1234; d_req[0] = 1'b1;
    total++; if (mem_nwe[0] !== 1'b1) $display("FAIL wr_nwe_pre: got %b want 1", mem_nwe[0]); else pass_cnt++;
    tick();
    total++; if (mem_nwe[0] !== 1'b0) $display("FAIL wr_nwe_e0: got %b want 0", mem_nwe[0]); else pass_cnt++;
    total++; if (mem_wdata[0] !== 16'h1234) $display("FAIL wr_wdata: got %h want 1234", mem_wdata[0]); else pass_cnt++;
    total++; if (mem_addr[0] !== 16'h0040) $display("FAIL wr_addr: got %h want 0040", mem_addr[0]); else pass_cnt++;
    total++; if (d_ack[0] !== 1'b0) $display("FAIL wr_ack_e0: got %b want 0", d_ack[0]); else pass_cnt++;
    tick();
    total++; if (mem_nwe[0] !== 1'b1) $display("FAIL wr_nwe_e1: got %b want 1", mem_nwe[0]); else pass_cnt++;
    total++; if (d_ack[0] !== 1'b1) $display("FAIL wr_ack_e1: got %b want 1", d_ack[0]); else pass_cnt++;
    total++; if (c_ack[0] !== 1'b0) $display("FAIL wr_c_ack: got %b want 0", c_ack[0]); else pass_cnt++;
    d_req[0] = 1'b0; d_we[0] = 1'b0;
    tick();
    total++; if (d_ack[0] !== 1'b0) $display("FAIL wr_ack_e2: got %b want 0", d_ack[0]); else pass_cnt++;
    c_addr[0] = 16'h0040; c_we[0] = 1'b0; c_req[0] = 1'b1;
    tick();
    tick();
    total++; if (c_ack[0] !== 1'b1) $display("FAIL wr_readback_ack: got %b want 1", c_ack[0]); else pass_cnt++;
    total++; if (c_rdata[0] !== 16'h1234) $display("FAIL wr_readback: got %h want 1234", c_rdata[0]); else pass_cnt++;
    c_req[0] = 1'b0;
    tick();
  endtask

  task automatic test_contention;
    int n = 0;
    int at[4];
    bit who[4], g[4];
    bit both = 0;
    do_reset();
    c_addr[1] = 16'h0010; d_addr[1] = 16'h0020; c_we[1] = 1'b0; d_we[1] = 1'b0;
    c_req[1] = 1'b1; d_req[1] = 1'b1;
    for (int cyc = 1; cyc <= 30 && n < 4; cyc++) begin
      tick();
      if (c_ack[1] && d_ack[1]) both = 1;
      if (c_ack[1] || d_ack[1]) begin
        who[n] = d_ack[1]; g[n] = gnt_d[1]; at[n] = cyc; n++;
      end
    end
    c_req[1] = 1'b0; d_req[1] = 1'b0;
    repeat (3) tick();
    total++; if (n != 4) $display("FAIL cont_count: got %0d acks want 4", n); else pass_cnt++;
    total++; if (both) $display("FAIL cont_both_ack: got 1 want 0"); else pass_cnt++;
    total++; if (n > 0 && at[0] != 3) $display("FAIL cont_first_at: got cycle %0d want 3", at[0]); else pass_cnt++;
    for (int i = 0; i < n; i++) begin
      total++; if (who[i] != i[0]) $display("FAIL cont_order[%0d]: got %0d want %0d", i, who[i], i[0]); else pass_cnt++;
      total++; if (g[i] != i[0]) $display("FAIL cont_gnt_d[%0d]: got %0d want %0d", i, g[i], i[0]); else pass_cnt++;
      if (i > 0) begin
        total++; if (at[i] - at[i-1] != 4) $display("FAIL cont_spacing[%0d]: got %0d want 4", i, at[i] - at[i-1]); else pass_cnt++;
      end
    end
    total++; if (d_rdata[1] !== 16'hA520) $display("FAIL cont_d_rdata: got %h want A520", d_rdata[1]); else pass_cnt++;
  endtask

  task automatic test_abort;
    int acks = 0;
    int when = 0;
    d_we[2] = 1'b1; d_addr[2] = 16'h0050; d_wdata[2] = 16'h5555; d_req[2] = 1'b1;
    tick();
    total++; if (mem_nwe[2] !== 1'b0) $display("FAIL abort_nwe_e0: got %b want 0", mem_nwe[2]); else pass_cnt++;
    tick();
    tick();
    #2 rst = 1'b1;
    d_req[2] = 1'b0; d_we[2] = 1'b0;
    #1;
    total++; if (mem_nwe[2] !== 1'b1) $display("FAIL abort_nwe: got %b want 1", mem_nwe[2]); else pass_cnt++;
    total++; if (busy[2] !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy[2]); else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      acks += int'(d_ack[2]);
    end
    total++; if (acks != 0) $display("FAIL abort_d_ack: got %0d pulses want 0", acks); else pass_cnt++;
    c_addr[2] = 16'h0050; c_we[2] = 1'b0; c_req[2] = 1'b1;
    for (int cyc = 1; cyc <= 10 && when == 0; cyc++) begin
      tick();
      if (c_ack[2]) when = cyc;
    end
    c_req[2] = 1'b0;
    total++; if (when != 5) $display("FAIL abort_next_ack: got cycle %0d want 5", when); else pass_cnt++;
    total++; if (c_rdata[2] !== 16'hA550) $display("FAIL abort_old_value: got %h want A550", c_rdata[2]); else pass_cnt++;
    repeat (2) tick();
  endtask

  task automatic test_early_drop;
    int acks = 0;
    int busy_n = 0;
    c_addr[1] = 16'h0020; c_we[1] = 1'b0; c_req[1] = 1'b1;
    tick();
    c_req[1] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      acks += int'(c_ack[1]);
      busy_n += int'(busy[1]);
    end
    total++; if (acks != 1) $display("FAIL drop_acks: got %0d want 1", acks); else pass_cnt++;
    total++; if (busy_n != 2) $display("FAIL drop_busy_cycles: got %0d want 2", busy_n); else pass_cnt++;
    total++; if (c_rdata[1] !== 16'hA520) $display("FAIL drop_rdata: got %h want A520", c_rdata[1]); else pass_cnt++;
  endtask

  initial begin
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      c_req[k] = 1'b0; c_we[k] = 1'b0; c_addr[k] = '0; c_wdata[k] = '0;
      d_req[k] = 1'b0; d_we[k] = 1'b0; d_addr[k] = '0; d_wdata[k] = '0;
    end
    #2;
    test_reset();
    test_cpu_read();
    test_debug_write();
    test_contention();
    test_abort();
    test_early_drop();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
